// File: rtl/seq_player_ctrl.sv
// Playback controller for a rotating color-sequence register: shows each step's
// color for HOLD ticks, darkens for GAP ticks, then rotates the register home.
module seq_player_ctrl #(
   parameter int N    = 64,
   parameter int HOLD = 2,
   parameter int GAP  = 1
) (
   input  logic         clk_i,
   input  logic         rn_i,
   input  logic         start_i,
   input  logic [3:0]   round_i,
   input  logic         tick_i,
   input  logic [N-1:0] seq_i,
   output logic         ld_o,
   output logic [N-1:0] data_o,
   output logic [3:0]   led_o,
   output logic         busy_o,
   output logic         done_o,
   output logic [2:0]   state_o
);

   // Tick counter only has to reach max(HOLD, GAP) - 1.
   localparam int MAXT     = (HOLD > GAP) ? HOLD : GAP;
   localparam int TW       = (MAXT < 2) ? 1 : $clog2(MAXT);
   localparam int HOLD_L_I = (HOLD > 0) ? HOLD - 1 : 0;
   localparam int GAP_L_I  = (GAP > 0) ? GAP - 1 : 0;
   localparam logic [TW-1:0] HOLD_LAST = TW'(HOLD_L_I);
   localparam logic [TW-1:0] GAP_LAST  = TW'(GAP_L_I);
   localparam logic [4:0]    FULL_ROT  = 5'd16;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_SHOW    = 3'd1,
      S_GAP     = 3'd2,
      S_RESTORE = 3'd3,
      S_DONE    = 3'd4
   } state_t;

   state_t        state_q, state_d;
   logic [TW-1:0] tick_q, tick_d;
   logic [4:0]    step_q, step_d;
   logic [3:0]    round_q, round_d;
   logic [4:0]    step_inc;
   logic [4:0]    steps_total;

   assign data_o      = {seq_i[N-5:0], seq_i[N-1:N-4]};
   assign step_inc    = step_q + 5'd1;
   assign steps_total = {1'b0, round_q} + 5'd1;
   assign busy_o      = (state_q != S_IDLE);
   assign state_o     = state_q;

   always_ff @(posedge clk_i or negedge rn_i) begin
      if (!rn_i) begin
         state_q <= S_IDLE;
         tick_q  <= '0;
         step_q  <= '0;
         round_q <= '0;
      end else begin
         state_q <= state_d;
         tick_q  <= tick_d;
         step_q  <= step_d;
         round_q <= round_d;
      end
   end

   // start_i is a request, not a handshake: it is sampled only while busy_o is
   // low, and busy_o rising is the acknowledgement.
   always_comb begin
      state_d = state_q;
      tick_d  = tick_q;
      step_d  = step_q;
      round_d = round_q;
      ld_o    = 1'b0;
      led_o   = 4'd0;
      done_o  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               round_d = round_i;
               step_d  = '0;
               tick_d  = '0;
               state_d = S_SHOW;
            end
         end
         S_SHOW: begin
            led_o = seq_i[N-1:N-4];
            if (tick_i) begin
               if (tick_q == HOLD_LAST) begin
                  ld_o   = 1'b1;
                  step_d = step_inc;
                  tick_d = '0;
                  // Without a dark phase the continue/restore decision uses the
                  // step count that includes the step just finished.
                  if (GAP == 0) begin
                     state_d = (step_inc < steps_total) ? S_SHOW : S_RESTORE;
                  end else begin
                     state_d = S_GAP;
                  end
               end else begin
                  tick_d = tick_q + TW'(1);
               end
            end
         end
         S_GAP: begin
            if (tick_i) begin
               if (tick_q == GAP_LAST) begin
                  tick_d  = '0;
                  state_d = (step_q < steps_total) ? S_SHOW : S_RESTORE;
               end else begin
                  tick_d = tick_q + TW'(1);
               end
            end
         end
         S_RESTORE: begin
            // Finish the full 16-step rotation so the register ends where it began.
            if (step_q < FULL_ROT) begin
               ld_o   = 1'b1;
               step_d = step_inc;
            end else begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            done_o  = 1'b1;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_seq_player_ctrl.sv
// Directed bench for seq_player_ctrl: two instances (GAP=1 and GAP=0) each
// driving a modelled sequence register, with a color scoreboard on step exits.
module tb_seq_player_ctrl;

   localparam logic [63:0] SEQ1 = 64'h1248_8421_1248_8421;
   localparam logic [63:0] SEQ2 = 64'h8421_2481_4812_1842;

   logic        clk;
   logic        rn;
   logic        tick;
   logic [3:0]  round_i;
   logic        start_a, start_b;
   logic        load_a, load_b;
   logic [63:0] load_val;
   logic [63:0] reg_a, reg_b;
   logic        ld_a, ld_b;
   logic [63:0] data_a, data_b;
   logic [3:0]  led_a, led_b;
   logic        busy_a, busy_b;
   logic        done_a, done_b;
   logic [2:0]  state_a, state_b;

   int checks = 0;
   int errors = 0;
   logic [3:0] exp_q[$];

   int show_ld_a, restore_ld_a, done_cnt_a, lit_ticks_a, edges_a;
   int show_ld_b, restore_ld_b, done_cnt_b, lit_ticks_b;
   logic [3:0] prev_led_a;

   seq_player_ctrl #(.N(64), .HOLD(2), .GAP(1)) u_dut_a (
      .clk_i(clk), .rn_i(rn), .start_i(start_a), .round_i(round_i), .tick_i(tick),
      .seq_i(reg_a), .ld_o(ld_a), .data_o(data_a), .led_o(led_a),
      .busy_o(busy_a), .done_o(done_a), .state_o(state_a)
   );

   seq_player_ctrl #(.N(64), .HOLD(2), .GAP(0)) u_dut_b (
      .clk_i(clk), .rn_i(rn), .start_i(start_b), .round_i(round_i), .tick_i(tick),
      .seq_i(reg_b), .ld_o(ld_b), .data_o(data_b), .led_o(led_b),
      .busy_o(busy_b), .done_o(done_b), .state_o(state_b)
   );

   // clock / reset-independent stimulus
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      tick = 1'b0;
      forever begin
         @(posedge clk);
         #1 tick = ($urandom_range(0, 2) == 0);
      end
   end

   // sequence register models sharing the reset
   always @(posedge clk or negedge rn) begin
      if (!rn)        reg_a <= '0;
      else if (load_a) reg_a <= load_val;
      else if (ld_a)   reg_a <= data_a;
   end

   always @(posedge clk or negedge rn) begin
      if (!rn)        reg_b <= '0;
      else if (load_b) reg_b <= load_val;
      else if (ld_b)   reg_b <= data_b;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic sb_pop(input string tag, input logic [3:0] led);
      logic [3:0] e;
      checks++;
      assert (exp_q.size() > 0) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=<none queued>", tag, led);
      end
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check(tag, {60'd0, led}, {60'd0, e});
      end
   endtask

   // scoreboard / monitor on the falling edge
   always @(negedge clk) begin
      if (!rn) begin
         prev_led_a = 4'd0;
      end else begin
         if (ld_a && led_a != 4'd0) begin
            sb_pop("step_color_a", led_a);
            show_ld_a++;
         end
         if (ld_a && led_a == 4'd0) restore_ld_a++;
         if (done_a) done_cnt_a++;
         if (tick && led_a != 4'd0) lit_ticks_a++;
         if (led_a != 4'd0 && prev_led_a == 4'd0) edges_a++;
         prev_led_a = led_a;
         if (ld_b && led_b != 4'd0) begin
            sb_pop("step_color_b", led_b);
            show_ld_b++;
         end
         if (ld_b && led_b == 4'd0) restore_ld_b++;
         if (done_b) done_cnt_b++;
         if (tick && led_b != 4'd0) lit_ticks_b++;
      end
   end

   // driver tasks
   task automatic clear_counts();
      show_ld_a = 0; restore_ld_a = 0; done_cnt_a = 0; lit_ticks_a = 0; edges_a = 0;
      show_ld_b = 0; restore_ld_b = 0; done_cnt_b = 0; lit_ticks_b = 0;
   endtask

   task automatic load_seq(input bit sel, input logic [63:0] val);
      @(posedge clk);
      #1 load_val = val;
      if (sel) load_b = 1'b1; else load_a = 1'b1;
      @(posedge clk);
      #1 load_a = 1'b0;
      load_b = 1'b0;
   endtask

   task automatic push_colors(input logic [63:0] s, input int steps);
      logic [63:0] t;
      t = s;
      for (int k = 0; k < steps; k++) begin
         exp_q.push_back(t[63:60]);
         t = {t[59:0], t[63:60]};
      end
   endtask

   task automatic play(input bit sel, input logic [3:0] rnd, input bit harass, input int budget);
      bit got;
      int idle_cyc;
      got = 1'b0;
      idle_cyc = 0;
      @(posedge clk);
      #1 round_i = rnd;
      if (sel) start_b = 1'b1; else start_a = 1'b1;
      @(posedge clk);
      #1 start_a = 1'b0;
      start_b = 1'b0;
      for (int i = 0; i < budget && !got; i++) begin
         @(negedge clk);
         if (sel ? done_b : done_a) got = 1'b1;
         if (!(sel ? busy_b : busy_a)) idle_cyc++;
         if (harass && !got) begin
            @(posedge clk);
            #1 start_a = 1'($urandom_range(0, 1));
            round_i = 4'($urandom_range(4, 15));
         end
      end
      start_a = 1'b0;
      check(sel ? "done_seen_b" : "done_seen_a", {63'd0, got}, 64'd1);
      check("busy_held", 64'(idle_cyc), 64'd0);
      @(negedge clk);
      check("idle_after_done", {63'd0, sel ? busy_b : busy_a}, 64'd0);
   endtask

   initial begin
      rn = 1'b0;
      round_i = 4'd0;
      start_a = 1'b0; start_b = 1'b0;
      load_a = 1'b0;  load_b = 1'b0;
      load_val = '0;
      clear_counts();
      prev_led_a = 4'd0;

      // reset state
      #12;
      check("rst_ld_a", {63'd0, ld_a}, 64'd0);
      check("rst_led_a", {60'd0, led_a}, 64'd0);
      check("rst_busy_a", {63'd0, busy_a}, 64'd0);
      check("rst_done_a", {63'd0, done_a}, 64'd0);
      check("rst_busy_b", {63'd0, busy_b}, 64'd0);
      @(posedge clk);
      #1 rn = 1'b1;

      load_seq(1'b0, SEQ1);
      load_seq(1'b1, SEQ1);
      @(negedge clk);
      check("data_rot", data_a, 64'h2488_4211_2488_4211);
      check("idle_led", {60'd0, led_a}, 64'd0);

      // round 2, GAP=1: colors 1,2,4 then 13-cycle restore
      clear_counts();
      exp_q.push_back(4'h1);
      exp_q.push_back(4'h2);
      exp_q.push_back(4'h4);
      play(1'b0, 4'd2, 1'b0, 3000);
      check("r2_show_ld", 64'(show_ld_a), 64'd3);
      check("r2_restore_ld", 64'(restore_ld_a), 64'd13);
      check("r2_done_cnt", 64'(done_cnt_a), 64'd1);
      check("r2_lit_ticks", 64'(lit_ticks_a), 64'd6);
      check("r2_dark_between", 64'(edges_a), 64'd3);
      check("r2_reg", reg_a, SEQ1);
      check("r2_q_empty", 64'(exp_q.size()), 64'd0);

      // round 15: all 16 steps, no restore pulses
      clear_counts();
      push_colors(SEQ1, 16);
      play(1'b0, 4'd15, 1'b0, 3000);
      check("r15_show_ld", 64'(show_ld_a), 64'd16);
      check("r15_restore_ld", 64'(restore_ld_a), 64'd0);
      check("r15_done_cnt", 64'(done_cnt_a), 64'd1);
      check("r15_dark_between", 64'(edges_a), 64'd16);
      check("r15_reg", reg_a, SEQ1);
      check("r15_q_empty", 64'(exp_q.size()), 64'd0);

      // GAP=0 instance, round 0
      clear_counts();
      exp_q.push_back(4'h1);
      play(1'b1, 4'd0, 1'b0, 3000);
      check("g0_show_ld", 64'(show_ld_b), 64'd1);
      check("g0_lit_ticks", 64'(lit_ticks_b), 64'd2);
      check("g0_restore_ld", 64'(restore_ld_b), 64'd15);
      check("g0_done_cnt", 64'(done_cnt_b), 64'd1);
      check("g0_reg", reg_b, SEQ1);

      // GAP=0, round 5: back-to-back SHOW steps
      clear_counts();
      push_colors(SEQ1, 6);
      play(1'b1, 4'd5, 1'b0, 3000);
      check("g0r5_show_ld", 64'(show_ld_b), 64'd6);
      check("g0r5_restore_ld", 64'(restore_ld_b), 64'd10);
      check("g0r5_reg", reg_b, SEQ1);

      // start/round harassment during playback
      clear_counts();
      push_colors(SEQ1, 4);
      play(1'b0, 4'd3, 1'b1, 3000);
      check("hr_show_ld", 64'(show_ld_a), 64'd4);
      check("hr_restore_ld", 64'(restore_ld_a), 64'd12);
      check("hr_done_cnt", 64'(done_cnt_a), 64'd1);
      check("hr_reg", reg_a, SEQ1);
      check("hr_q_empty", 64'(exp_q.size()), 64'd0);

      // asynchronous reset during the second SHOW step
      clear_counts();
      push_colors(SEQ1, 6);
      @(posedge clk);
      #1 round_i = 4'd5;
      start_a = 1'b1;
      @(posedge clk);
      #1 start_a = 1'b0;
      begin
         bit reached;
         reached = 1'b0;
         for (int i = 0; i < 2000 && !reached; i++) begin
            @(negedge clk);
            if (show_ld_a == 1 && led_a != 4'd0) reached = 1'b1;
         end
         check("second_show_reached", {63'd0, reached}, 64'd1);
      end
      #2 rn = 1'b0;
      #1;
      check("arst_ld", {63'd0, ld_a}, 64'd0);
      check("arst_led", {60'd0, led_a}, 64'd0);
      check("arst_busy", {63'd0, busy_a}, 64'd0);
      check("arst_done", {63'd0, done_a}, 64'd0);
      check("arst_reg", reg_a, 64'd0);
      exp_q.delete();
      @(posedge clk);
      @(posedge clk);
      #1 rn = 1'b1;

      load_seq(1'b0, SEQ2);
      clear_counts();
      push_colors(SEQ2, 5);
      play(1'b0, 4'd4, 1'b0, 3000);
      check("post_rst_show_ld", 64'(show_ld_a), 64'd5);
      check("post_rst_restore_ld", 64'(restore_ld_a), 64'd11);
      check("post_rst_reg", reg_a, SEQ2);
      check("post_rst_q_empty", 64'(exp_q.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
